// File: rtl/nmul_arb_pkg.sv
// Shared types and helpers for the round-robin multiplier arbiter.
// Holds FSM encoding, id width helper and the rotating priority picker.
package nmul_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Picker is written for up to RR_MAX requesters; callers zero-extend.
  localparam int RR_MAX = 32;
  localparam int RR_IDW = 5;

  typedef struct packed {
    logic              vld;
    logic [RR_IDW-1:0] idx;
  } rr_pick_t;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // First set bit scanning last+1, last+2, ... wrapping at n.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] req,
                                       input int n,
                                       input int last);
    rr_pick_t pick;
    int       idx;
    pick = '0;
    for (int k = 1; k <= RR_MAX; k++) begin
      if (k <= n) begin
        idx = last + k;
        if (idx >= n) idx = idx - n;
        if (!pick.vld && req[idx[RR_IDW-1:0]]) begin
          pick.vld = 1'b1;
          pick.idx = idx[RR_IDW-1:0];
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/nmul_stage.sv
// Registered unsigned Nsize x Nsize multiply, one cycle latency when en is high.
// Product holds its value while en is low; no backpressure.
module nmul_stage #(
  parameter int Nsize = 16
) (
  input  logic               Clk,
  input  logic               Clr,
  input  logic               en,
  input  logic [Nsize-1:0]   a,
  input  logic [Nsize-1:0]   b,
  output logic [2*Nsize-1:0] p
);

  localparam int PW = 2 * Nsize;

  always_ff @(posedge Clk) begin
    if (Clr) begin
      p <= '0;
    end else if (en) begin
      p <= PW'(a) * PW'(b);
    end
  end

endmodule

// File: rtl/nmul_rr_arbiter.sv
// Round-robin sequencer sharing one registered multiplier among NREQ clients.
// Grant-to-result 2 edges, one op per 2 cycles; requests are ignored while BUSY.
module nmul_rr_arbiter
  import nmul_arb_pkg::*;
#(
  parameter int Nsize = 16,
  parameter int NREQ  = 4,
  parameter int CntW  = 16
) (
  input  logic                        Clk,
  input  logic                        Clr,
  input  logic [NREQ-1:0]             Req,
  input  logic [NREQ*Nsize-1:0]       A,
  input  logic [NREQ*Nsize-1:0]       B,
  output logic [NREQ-1:0]             Gnt,
  output logic [2*Nsize-1:0]          R,
  output logic                        RValid,
  output logic [id_width(NREQ)-1:0]   RId,
  output logic                        Busy,
  output logic [CntW-1:0]             OpCount
);

  localparam int IdW = id_width(NREQ);

  state_e           state_q, state_d;
  rr_pick_t         pick;
  logic [IdW-1:0]   win_idx;
  logic [IdW-1:0]   last_q;
  logic [IdW-1:0]   id_q;
  logic [Nsize-1:0] op_a, op_b;
  logic             grant;
  logic             fire;
  logic [NREQ-1:0]  gnt_d;

  assign pick    = rr_pick(RR_MAX'(Req), NREQ, int'(last_q));
  assign win_idx = IdW'(pick.idx);

  always_ff @(posedge Clk) begin
    if (Clr) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick.vld) state_d = BUSY;
      BUSY:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant = (state_q == IDLE) && pick.vld;
    fire  = (state_q == BUSY);
    gnt_d = grant ? (NREQ'(1) << win_idx) : '0;
  end

  // Operands are latched at grant so clients may change A/B while BUSY.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      Gnt     <= '0;
      RValid  <= 1'b0;
      RId     <= '0;
      OpCount <= '0;
      last_q  <= IdW'(NREQ - 1);
      id_q    <= '0;
      op_a    <= '0;
      op_b    <= '0;
    end else begin
      Gnt    <= gnt_d;
      RValid <= fire;
      if (grant) begin
        op_a   <= A[win_idx*Nsize +: Nsize];
        op_b   <= B[win_idx*Nsize +: Nsize];
        id_q   <= win_idx;
        last_q <= win_idx;
      end
      if (fire) begin
        RId     <= id_q;
        OpCount <= OpCount + CntW'(1);
      end
    end
  end

  assign Busy = (state_q == BUSY);

  nmul_stage #(.Nsize(Nsize)) u_mul (
    .Clk (Clk),
    .Clr (Clr),
    .en  (fire),
    .a   (op_a),
    .b   (op_b),
    .p   (R)
  );

endmodule

// File: tb/tb_nmul_rr_arbiter.sv
// Directed bench for nmul_rr_arbiter at Nsize=8, NREQ=4, CntW=4.
// Single-op table followed by fairness, drop, mid-op clear and counter wrap sequences.
module tb_nmul_rr_arbiter;

  logic        Clk;
  logic        Clr;
  logic [3:0]  Req;
  logic [31:0] A, B;
  logic [3:0]  Gnt;
  logic [15:0] R;
  logic        RValid;
  logic [1:0]  RId;
  logic        Busy;
  logic [3:0]  OpCount;

  int tests  = 0;
  int failed = 0;

  nmul_rr_arbiter #(.Nsize(8), .NREQ(4), .CntW(4)) dut (
    .Clk     (Clk),
    .Clr     (Clr),
    .Req     (Req),
    .A       (A),
    .B       (B),
    .Gnt     (Gnt),
    .R       (R),
    .RValid  (RValid),
    .RId     (RId),
    .Busy    (Busy),
    .OpCount (OpCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [3:0]  req;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  gnt;
    int          rid;
    logic [15:0] r;
  } vec_t;

  vec_t tbl[8];

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  int exp_cnt;

  initial begin
    // Pointer starts at 3 after reset; each row's winner is derived by hand.
    tbl[0] = '{4'b0001, 8'd200, 8'd150, 4'b0001, 0, 16'd30000};
    tbl[1] = '{4'b0010, 8'd255, 8'd255, 4'b0010, 1, 16'd65025};
    tbl[2] = '{4'b0101, 8'd0,   8'd255, 4'b0100, 2, 16'd0};
    tbl[3] = '{4'b0101, 8'd12,  8'd13,  4'b0001, 0, 16'd156};
    tbl[4] = '{4'b1010, 8'd3,   8'd100, 4'b0010, 1, 16'd300};
    tbl[5] = '{4'b1010, 8'd128, 8'd2,   4'b1000, 3, 16'd256};
    tbl[6] = '{4'b1111, 8'd1,   8'd1,   4'b0001, 0, 16'd1};
    tbl[7] = '{4'b1000, 8'd17,  8'd15,  4'b1000, 3, 16'd255};

    Clr = 1'b1; Req = '0; A = '0; B = '0;
    step();
    step();
    chk("rst_gnt", Gnt, 0);
    chk("rst_rvalid", RValid, 0);
    chk("rst_r", R, 0);
    chk("rst_rid", RId, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_opcount", OpCount, 0);
    Clr = 1'b0;

    exp_cnt = 0;
    foreach (tbl[i]) begin
      A = {4{8'd7}};
      B = {4{8'd9}};
      A[tbl[i].rid*8 +: 8] = tbl[i].a;
      B[tbl[i].rid*8 +: 8] = tbl[i].b;
      Req = tbl[i].req;
      step();
      chk($sformatf("tbl%0d_gnt", i), Gnt, tbl[i].gnt);
      chk($sformatf("tbl%0d_busy", i), Busy, 1);
      chk($sformatf("tbl%0d_rvalid_lo", i), RValid, 0);
      Req = '0;
      A = '1;
      B = '1;
      step();
      exp_cnt = (exp_cnt + 1) % 16;
      chk($sformatf("tbl%0d_rvalid", i), RValid, 1);
      chk($sformatf("tbl%0d_r", i), R, tbl[i].r);
      chk($sformatf("tbl%0d_rid", i), RId, tbl[i].rid);
      chk($sformatf("tbl%0d_gnt_lo", i), Gnt, 0);
      chk($sformatf("tbl%0d_opcount", i), OpCount, exp_cnt);
    end

    step();
    chk("idle_rvalid", RValid, 0);
    chk("idle_gnt", Gnt, 0);
    chk("idle_r_hold", R, 255);

    // Fairness: all requesting continuously; grants rotate 0,1,2,3,0.
    A = {8'd4, 8'd3, 8'd2, 8'd1};
    B = {4{8'd10}};
    Req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("fair%0d_gnt", k), Gnt, 4'b0001 << (k % 4));
      chk($sformatf("fair%0d_rvalid_lo", k), RValid, 0);
      step();
      chk($sformatf("fair%0d_rvalid", k), RValid, 1);
      chk($sformatf("fair%0d_gnt_lo", k), Gnt, 0);
      chk($sformatf("fair%0d_rid", k), RId, k % 4);
      chk($sformatf("fair%0d_r", k), R, ((k % 4) + 1) * 10);
    end
    Req = '0;

    // Requester that drops Req after its grant is not granted again.
    A[16 +: 8] = 8'd5;
    B[16 +: 8] = 8'd5;
    Req = 4'b0100;
    step();
    chk("drop_gnt", Gnt, 4'b0100);
    Req = '0;
    step();
    chk("drop_r", R, 25);
    step();
    chk("drop_no_regrant", Gnt, 0);
    chk("drop_busy", Busy, 0);

    // Clear in the BUSY cycle discards the operation and resets the pointer.
    Req = 4'b0100;
    step();
    chk("clr_gnt", Gnt, 4'b0100);
    chk("clr_busy_hi", Busy, 1);
    Clr = 1'b1;
    Req = '0;
    step();
    chk("clr_rvalid", RValid, 0);
    chk("clr_gnt_lo", Gnt, 0);
    chk("clr_busy", Busy, 0);
    chk("clr_r", R, 0);
    chk("clr_rid", RId, 0);
    chk("clr_opcount", OpCount, 0);
    Clr = 1'b0;
    A = {8'd4, 8'd3, 8'd2, 8'd1};
    Req = 4'b1111;
    step();
    chk("post_clr_gnt", Gnt, 4'b0001);
    Req = '0;
    step();
    chk("post_clr_rid", RId, 0);
    chk("post_clr_r", R, 10);
    chk("post_clr_opcount", OpCount, 1);

    // Counter wraps modulo 16 across 17 back-to-back operations.
    Clr = 1'b1;
    step();
    Clr = 1'b0;
    A = {8'd0, 8'd0, 8'd0, 8'd2};
    B = {8'd0, 8'd0, 8'd0, 8'd3};
    Req = 4'b0001;
    for (int k = 1; k <= 17; k++) begin
      step();
      chk($sformatf("wrap%0d_gnt", k), Gnt, 4'b0001);
      step();
      chk($sformatf("wrap%0d_r", k), R, 6);
      chk($sformatf("wrap%0d_opcount", k), OpCount, k % 16);
    end
    Req = '0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
